// File: rtl/lpif_pkg.sv
// lpif_pkg: types, defaults and small helpers shared by the LPIF transmit path.
package lpif_pkg;

  // Beat width the transmit path is normally built for.
  localparam int LPIF_NBYTES_DEFAULT = 8;

  // Transmit-side flow states: normal streaming, finishing the open TLP
  // before honouring a stall, and parked at a TLP boundary.
  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DRAIN   = 2'd1,
    STALLED = 2'd2
  } lpif_state_e;

  // Index of the most significant set bit, or -1 when no bit is set.
  function automatic int highest_set(input logic [63:0] v);
    int idx;
    idx = -1;
    for (int i = 0; i < 64; i++) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

  // A TLP is left open by a beat when its last start marker comes after its
  // last end marker; a beat without starts can only close an open TLP.
  function automatic logic next_open(input logic        cur,
                                     input logic [63:0] starts,
                                     input logic [63:0] ends);
    if (|starts) begin
      return highest_set(starts) > highest_set(ends);
    end
    return cur && !(|ends);
  endfunction

endpackage

// File: rtl/lpif_sync_fifo.sv
// lpif_sync_fifo: single-clock FIFO with registered read pointer and an
// occupancy count; pointers wrap naturally because DEPTH is a power of two.
module lpif_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A pop needs an entry; a push needs a free slot or a slot freed this cycle.
  assign do_pop  = pop && (level != '0);
  assign do_push = push && ((level != LW'(DEPTH)) || do_pop);

  assign rd_data = mem[rd_ptr];

  // Storage array; contents need no reset because level gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // Pointer and occupancy bookkeeping, cleared asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/lpif_tx_fifo.sv
// lpif_tx_fifo: buffers LPIF beats towards the PHY and honours PHY stall
// requests only at TLP boundaries, tracking open TLPs on both FIFO sides.
module lpif_tx_fifo
  import lpif_pkg::*;
#(
  parameter int NBYTES = LPIF_NBYTES_DEFAULT,
  parameter int DEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NBYTES*8-1:0]       lp_data,
  input  logic [NBYTES-1:0]         lp_valid,
  input  logic [NBYTES-1:0]         lp_tlp_start,
  input  logic [NBYTES-1:0]         lp_tlp_end,
  input  logic                      lp_irdy,
  output logic                      pl_trdy,
  input  logic                      pl_stall_req,
  output logic                      lp_stall_ack,
  output logic [NBYTES*8-1:0]       phy_data,
  output logic [NBYTES-1:0]         phy_valid,
  output logic [NBYTES-1:0]         phy_tlp_start,
  output logic [NBYTES-1:0]         phy_tlp_end,
  output logic                      phy_vld,
  input  logic                      phy_rdy,
  output logic [$clog2(DEPTH):0]    level
);

  localparam int W  = NBYTES * 8;
  localparam int EW = W + 3 * NBYTES;
  localparam int LW = $clog2(DEPTH) + 1;

  lpif_state_e       state;
  lpif_state_e       state_nxt;
  logic              live;
  logic              in_open;
  logic              out_open;
  logic              in_open_nxt;
  logic              out_open_nxt;
  logic              push;
  logic              pop;
  logic              has_data;
  logic              has_room;
  logic [EW-1:0]     wr_entry;
  logic [EW-1:0]     rd_entry;
  logic [W-1:0]      head_data;
  logic [NBYTES-1:0] head_valid;
  logic [NBYTES-1:0] head_start;
  logic [NBYTES-1:0] head_end;

  assign wr_entry = {lp_tlp_start, lp_tlp_end, lp_valid, lp_data};
  assign {head_start, head_end, head_valid, head_data} = rd_entry;

  assign has_data = (level != '0);
  assign has_room = (level < LW'(DEPTH));

  // Empty beats are acknowledged but never stored.
  assign push = lp_irdy && pl_trdy && (|lp_valid);
  assign pop  = phy_vld && phy_rdy;

  lpif_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_store (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .wr_data (wr_entry),
    .pop     (pop),
    .rd_data (rd_entry),
    .level   (level)
  );

  // Holds off acceptance until the first clock edge after reset is released.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) live <= 1'b0;
    else          live <= 1'b1;
  end

  // Open-TLP tracking advances only on beats that actually move.
  always_comb begin
    in_open_nxt  = in_open;
    out_open_nxt = out_open;
    if (push) in_open_nxt  = next_open(in_open, 64'(lp_tlp_start), 64'(lp_tlp_end));
    if (pop)  out_open_nxt = next_open(out_open, 64'(head_start), 64'(head_end));
  end

  // Registers the open-TLP flags for both sides of the FIFO.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_open  <= 1'b0;
      out_open <= 1'b0;
    end else begin
      in_open  <= in_open_nxt;
      out_open <= out_open_nxt;
    end
  end

  // Flow-state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= RUN;
    else          state <= state_nxt;
  end

  // Stall entry waits for the outgoing TLP to close, judged after this cycle's pop.
  always_comb begin
    state_nxt = state;
    case (state)
      RUN: begin
        if (pl_stall_req) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (!pl_stall_req)     state_nxt = RUN;
        else if (!out_open_nxt) state_nxt = STALLED;
      end
      STALLED: begin
        if (!pl_stall_req) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  // Handshake outputs per state; DRAIN only lets the open TLP finish.
  always_comb begin
    pl_trdy      = 1'b0;
    phy_vld      = 1'b0;
    lp_stall_ack = 1'b0;
    case (state)
      RUN: begin
        pl_trdy = live && has_room;
        phy_vld = has_data;
      end
      DRAIN: begin
        pl_trdy = live && has_room && in_open;
        phy_vld = has_data && out_open;
      end
      STALLED: begin
        lp_stall_ack = 1'b1;
      end
      default: begin
        pl_trdy = 1'b0;
      end
    endcase
  end

  // Head entry is presented only while the FIFO holds something.
  always_comb begin
    phy_data      = '0;
    phy_valid     = '0;
    phy_tlp_start = '0;
    phy_tlp_end   = '0;
    if (has_data) begin
      phy_data      = head_data;
      phy_valid     = head_valid;
      phy_tlp_start = head_start;
      phy_tlp_end   = head_end;
    end
  end

endmodule

// File: tb/tb_lpif_tx_fifo.sv
// tb_lpif_tx_fifo: directed scoreboard bench for lpif_tx_fifo (NBYTES=8, DEPTH=4).
module tb_lpif_tx_fifo;

  localparam int NB = 8;
  localparam int DP = 4;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  valid;
    logic [7:0]  start;
    logic [7:0]  fin;
  } beat_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [63:0]   lp_data;
  logic [7:0]    lp_valid;
  logic [7:0]    lp_tlp_start;
  logic [7:0]    lp_tlp_end;
  logic          lp_irdy;
  logic          pl_trdy;
  logic          pl_stall_req;
  logic          lp_stall_ack;
  logic [63:0]   phy_data;
  logic [7:0]    phy_valid;
  logic [7:0]    phy_tlp_start;
  logic [7:0]    phy_tlp_end;
  logic          phy_vld;
  logic          phy_rdy;
  logic [2:0]    level;

  int    errors = 0;
  int    checks = 0;
  int    pops   = 0;
  beat_t sb[$];

  lpif_tx_fifo #(
    .NBYTES (NB),
    .DEPTH  (DP)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .lp_data       (lp_data),
    .lp_valid      (lp_valid),
    .lp_tlp_start  (lp_tlp_start),
    .lp_tlp_end    (lp_tlp_end),
    .lp_irdy       (lp_irdy),
    .pl_trdy       (pl_trdy),
    .pl_stall_req  (pl_stall_req),
    .lp_stall_ack  (lp_stall_ack),
    .phy_data      (phy_data),
    .phy_valid     (phy_valid),
    .phy_tlp_start (phy_tlp_start),
    .phy_tlp_end   (phy_tlp_end),
    .phy_vld       (phy_vld),
    .phy_rdy       (phy_rdy),
    .level         (level)
  );

  always #5 clk = ~clk;

  function automatic beat_t mkBeat(input int k, input logic [7:0] v,
                                   input logic [7:0] s, input logic [7:0] e);
    beat_t b;
    b.data  = {32'hDA7A_0000 + 32'(k), 32'(k) * 32'h0101_0101};
    b.valid = v;
    b.start = s;
    b.fin   = e;
    return b;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock step: drive at the falling edge, sample 1ns later, score transfers.
  task automatic applyStimulus(input logic irdy, input beat_t b, input logic stall, input logic rdy);
    beat_t exp;
    @(negedge clk);
    lp_irdy      = irdy;
    lp_data      = b.data;
    lp_valid     = b.valid;
    lp_tlp_start = b.start;
    lp_tlp_end   = b.fin;
    pl_stall_req = stall;
    phy_rdy      = rdy;
    #1;
    if (phy_vld && !phy_rdy && sb.size() > 0)
      checkOutput("hold_data", phy_data, sb[0].data);
    if (phy_vld && phy_rdy) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_pop", 64'(phy_vld), 64'd0);
      end else begin
        exp = sb.pop_front();
        checkOutput("pop_data", phy_data, exp.data);
        checkOutput("pop_ctl", 64'({phy_valid, phy_tlp_start, phy_tlp_end}),
                    64'({exp.valid, exp.start, exp.fin}));
        pops++;
      end
    end
    if (lp_irdy && pl_trdy && (|lp_valid)) sb.push_back(b);
  endtask

  initial begin
    beat_t nb;
    beat_t hold5;
    int    p;
    nb           = '0;
    reset_n      = 1'b0;
    lp_irdy      = 1'b0;
    lp_data      = '0;
    lp_valid     = '0;
    lp_tlp_start = '0;
    lp_tlp_end   = '0;
    pl_stall_req = 1'b0;
    phy_rdy      = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_level", 64'(level), 64'd0);
    checkOutput("rst_phy_vld", 64'(phy_vld), 64'd0);
    checkOutput("rst_trdy", 64'(pl_trdy), 64'd0);
    checkOutput("rst_ack", 64'(lp_stall_ack), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    checkOutput("trdy_before_edge", 64'(pl_trdy), 64'd0);
    applyStimulus(1'b0, nb, 1'b0, 1'b1);
    checkOutput("trdy_after_reset", 64'(pl_trdy), 64'd1);

    // Back-to-back streaming with the PHY always ready
    $display("[TB] back-to-back streaming");
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b1, mkBeat(k, 8'hFF, 8'h01, 8'h80), 1'b0, 1'b1);
      if (k == 0) checkOutput("b2b_no_bypass", 64'(phy_vld), 64'd0);
      if (k == 1) checkOutput("b2b_first_out", 64'(phy_vld), 64'd1);
      checkOutput("b2b_level_le1", 64'(level > 3'd1), 64'd0);
    end
    applyStimulus(1'b0, nb, 1'b0, 1'b1);
    applyStimulus(1'b0, nb, 1'b0, 1'b1);
    checkOutput("b2b_pops", 64'(pops), 64'd10);
    checkOutput("b2b_empty_level", 64'(level), 64'd0);
    checkOutput("b2b_empty_vld", 64'(phy_vld), 64'd0);
    checkOutput("empty_data_zero", phy_data, 64'd0);
    checkOutput("empty_ctl_zero", 64'({phy_valid, phy_tlp_start, phy_tlp_end}), 64'd0);

    // Empty beat is discarded
    applyStimulus(1'b1, mkBeat(99, 8'h00, 8'h01, 8'h80), 1'b0, 1'b1);
    applyStimulus(1'b0, nb, 1'b0, 1'b1);
    checkOutput("empty_beat_level", 64'(level), 64'd0);
    checkOutput("empty_beat_vld", 64'(phy_vld), 64'd0);

    // Fill to full, back-pressure, then one pop frees a slot
    $display("[TB] full FIFO back-pressure");
    for (int k = 0; k < 4; k++)
      applyStimulus(1'b1, mkBeat(20 + k, (k == 2) ? 8'h0F : 8'hFF, 8'h01,
                                 (k == 2) ? 8'h08 : 8'h80), 1'b0, 1'b0);
    hold5 = mkBeat(24, 8'hFF, 8'h01, 8'h80);
    applyStimulus(1'b1, hold5, 1'b0, 1'b0);
    checkOutput("full_level", 64'(level), 64'd4);
    checkOutput("full_trdy", 64'(pl_trdy), 64'd0);
    applyStimulus(1'b1, hold5, 1'b0, 1'b1);
    checkOutput("full_trdy_at_pop", 64'(pl_trdy), 64'd0);
    applyStimulus(1'b1, hold5, 1'b0, 1'b0);
    checkOutput("trdy_after_pop", 64'(pl_trdy), 64'd1);
    applyStimulus(1'b0, nb, 1'b0, 1'b0);
    checkOutput("refill_level", 64'(level), 64'd4);
    repeat (5) applyStimulus(1'b0, nb, 1'b0, 1'b1);
    checkOutput("full_drained_level", 64'(level), 64'd0);
    checkOutput("full_drained_sb", 64'(sb.size()), 64'd0);

    // Stall requested mid-TLP
    $display("[TB] stall mid-TLP");
    applyStimulus(1'b1, mkBeat(30, 8'hFF, 8'h01, 8'h00), 1'b0, 1'b1);
    applyStimulus(1'b1, mkBeat(31, 8'hFF, 8'h00, 8'h00), 1'b1, 1'b1);
    applyStimulus(1'b1, mkBeat(32, 8'h0F, 8'h00, 8'h08), 1'b1, 1'b1);
    checkOutput("drain_trdy_open", 64'(pl_trdy), 64'd1);
    applyStimulus(1'b1, mkBeat(33, 8'hFF, 8'h01, 8'h80), 1'b1, 1'b1);
    checkOutput("drain_trdy_closed", 64'(pl_trdy), 64'd0);
    checkOutput("drain_last_vld", 64'(phy_vld), 64'd1);
    checkOutput("drain_ack_low", 64'(lp_stall_ack), 64'd0);
    applyStimulus(1'b1, mkBeat(33, 8'hFF, 8'h01, 8'h80), 1'b1, 1'b1);
    checkOutput("stall_ack", 64'(lp_stall_ack), 64'd1);
    checkOutput("stall_vld", 64'(phy_vld), 64'd0);
    checkOutput("stall_trdy", 64'(pl_trdy), 64'd0);
    checkOutput("stall_sb_empty", 64'(sb.size()), 64'd0);
    p = pops;
    applyStimulus(1'b1, mkBeat(33, 8'hFF, 8'h01, 8'h80), 1'b1, 1'b1);
    checkOutput("stall_ack_held", 64'(lp_stall_ack), 64'd1);

    // Stall release
    applyStimulus(1'b1, mkBeat(33, 8'hFF, 8'h01, 8'h80), 1'b0, 1'b1);
    checkOutput("release_ack_still", 64'(lp_stall_ack), 64'd1);
    checkOutput("stall_no_pops", 64'(pops - p), 64'd0);
    applyStimulus(1'b1, mkBeat(33, 8'hFF, 8'h01, 8'h80), 1'b0, 1'b1);
    checkOutput("release_ack_low", 64'(lp_stall_ack), 64'd0);
    checkOutput("release_trdy", 64'(pl_trdy), 64'd1);
    applyStimulus(1'b0, nb, 1'b0, 1'b1);
    applyStimulus(1'b0, nb, 1'b0, 1'b1);
    checkOutput("release_drained", 64'(level), 64'd0);

    // Stall withdrawn during drain
    $display("[TB] stall withdrawn in drain");
    applyStimulus(1'b1, mkBeat(40, 8'hFF, 8'h01, 8'h00), 1'b0, 1'b1);
    applyStimulus(1'b0, nb, 1'b1, 1'b1);
    applyStimulus(1'b0, nb, 1'b0, 1'b1);
    checkOutput("withdraw_ack_k", 64'(lp_stall_ack), 64'd0);
    applyStimulus(1'b1, mkBeat(41, 8'hFF, 8'h00, 8'h80), 1'b0, 1'b1);
    checkOutput("withdraw_ack_l", 64'(lp_stall_ack), 64'd0);
    checkOutput("withdraw_trdy", 64'(pl_trdy), 64'd1);
    applyStimulus(1'b0, nb, 1'b0, 1'b1);
    checkOutput("withdraw_ack_m", 64'(lp_stall_ack), 64'd0);
    applyStimulus(1'b0, nb, 1'b0, 1'b1);
    checkOutput("withdraw_sb_empty", 64'(sb.size()), 64'd0);

    // Reset in the middle of an open TLP
    $display("[TB] reset mid-packet");
    applyStimulus(1'b1, mkBeat(50, 8'hFF, 8'h01, 8'h00), 1'b0, 1'b0);
    applyStimulus(1'b1, mkBeat(51, 8'hFF, 8'h00, 8'h00), 1'b0, 1'b0);
    applyStimulus(1'b1, mkBeat(52, 8'hFF, 8'h00, 8'h00), 1'b0, 1'b0);
    applyStimulus(1'b1, mkBeat(53, 8'hFF, 8'h00, 8'h00), 1'b0, 1'b1);
    applyStimulus(1'b0, nb, 1'b0, 1'b0);
    checkOutput("pre_reset_level", 64'(level), 64'd3);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("async_rst_level", 64'(level), 64'd0);
    checkOutput("async_rst_vld", 64'(phy_vld), 64'd0);
    checkOutput("async_rst_trdy", 64'(pl_trdy), 64'd0);
    checkOutput("async_rst_data", phy_data, 64'd0);
    sb.delete();
    @(negedge clk);
    reset_n = 1'b1;
    p = pops;
    applyStimulus(1'b1, mkBeat(60, 8'h3C, 8'h04, 8'h20), 1'b0, 1'b0);
    checkOutput("post_rst_trdy", 64'(pl_trdy), 64'd1);
    applyStimulus(1'b0, nb, 1'b0, 1'b1);
    checkOutput("post_rst_popped", 64'(pops - p), 64'd1);
    applyStimulus(1'b0, nb, 1'b0, 1'b1);
    checkOutput("post_rst_empty", 64'(level), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Guards against a hung run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/lpif_tx_fifo.md
LPIF_TX_FIFO -- requirements
Module: lpif_tx_fifo

Interface
REQ-001 SHALL have parameter NBYTES, default 8, bytes per LPIF beat (legal 4, 8, 16, 32, 64).
REQ-002 SHALL have parameter DEPTH, default 4, FIFO entries (power of 2, >= 2).
REQ-003 SHALL provide ports, clock and reset first; one clock, reset asynchronous and active-low:
  clk            in   1             sole clock, rising edge
  reset_n        in   1             asynchronous active-low reset
  lp_data        in   NBYTES*8      link-layer beat data, byte i = bits 8i+7:8i
  lp_valid       in   NBYTES        per-byte valid
  lp_tlp_start   in   NBYTES        per-byte TLP start marker
  lp_tlp_end     in   NBYTES        per-byte TLP end marker
  lp_irdy        in   1             link layer offers beat
  pl_trdy        out  1             block accepts beat
  pl_stall_req   in   1             PHY stall request
  lp_stall_ack   out  1             stall acknowledged, TLP boundary reached
  phy_data       out  NBYTES*8      head-entry data
  phy_valid      out  NBYTES        head-entry byte valids
  phy_tlp_start  out  NBYTES        head-entry start markers
  phy_tlp_end    out  NBYTES        head-entry end markers
  phy_vld        out  1             head entry presented
  phy_rdy        in   1             PHY consumes head entry
  level          out  $clog2(DEPTH)+1   occupied entries

Function
REQ-004 SHALL push when lp_irdy && pl_trdy && |lp_valid; beats with lp_valid==0 SHALL be discarded, not stored.
REQ-005 SHALL pop when phy_vld && phy_rdy; pushed beat SHALL be visible on phy_* no earlier than the next cycle (1-cycle minimum latency, no bypass).
REQ-006 SHALL keep level unchanged on simultaneous push and pop, including when full; pointers SHALL wrap modulo DEPTH.
REQ-007 SHALL drive pl_trdy = (level < DEPTH) && (state==RUN || (state==DRAIN && in_open)); pl_trdy=0 in STALLED.
REQ-008 SHALL track in_open (push side) and out_open (pop side), updated per transferred beat: if |start, open = (highest start index > highest end index); else open = open && !(|end).
REQ-009 SHALL implement states RUN, DRAIN, STALLED.
REQ-010 RUN -> DRAIN when pl_stall_req=1.
REQ-011 In DRAIN, phy_vld SHALL equal (level>0) && out_open; DRAIN -> STALLED on the first cycle with out_open=0 after any pop that cycle completes.
REQ-012 In STALLED, lp_stall_ack=1 and phy_vld=0; STALLED -> RUN the cycle after pl_stall_req=0, lp_stall_ack deasserting on that same transition.
REQ-013 In RUN, phy_vld = (level>0).
REQ-014 pl_stall_req deasserting during DRAIN SHALL return to RUN next cycle without asserting lp_stall_ack.
REQ-015 phy_* data outputs SHALL hold stable while phy_vld && !phy_rdy.

Reset
REQ-016 On reset_n=0, asynchronously: state=RUN, pointers=0, level=0, in_open=out_open=0, phy_vld=0, lp_stall_ack=0, pl_trdy=0.
REQ-017 pl_trdy SHALL rise the first cycle after reset_n deasserts; reset mid-packet SHALL flush all entries.
REQ-018 phy_data/phy_valid/phy_tlp_* SHALL be 0 while level==0.

Structure
REQ-019 State enum (RUN/DRAIN/STALLED) and the default NBYTES constant SHALL live in shared package lpif_pkg.
REQ-020 Storage SHALL be a sub-module lpif_sync_fifo (parametrised width/depth, push/pop/level); state machine and open tracking stay in lpif_tx_fifo.

Verification
REQ-021 Back-to-back push, phy_rdy=1, NBYTES=8: 10 beats in -> 10 beats out in order, first on cycle N+1, level never exceeds 1.
REQ-022 phy_rdy=0, DEPTH=4: 4 pushes -> level=4, pl_trdy=0; 5th beat held by irdy; one pop -> 5th accepted next cycle, order preserved.
REQ-023 Stall mid-TLP: start in beat 0, end byte 3 of beat 2, stall_req at beat 1 -> beat 2 still accepted and popped, lp_stall_ack=1 the following cycle, no further pops.
REQ-024 Stall release: pl_stall_req 1->0 in STALLED -> lp_stall_ack=0 and pl_trdy=1 next cycle.
REQ-025 reset_n asserted with level=3 and out_open=1 -> level=0, phy_vld=0 immediately; post-reset beat emerges unaltered.
REQ-026 Beat with lp_valid=0 and lp_irdy=1 -> no level change, no phy output.
